// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: round-robin arbiter that shares one downstream OBI port
// between NUM_REQ upstream requesters with a single transaction in flight.
// The winner's request is captured at grant time, so the requester may drop
// or change its inputs right after gnt_o. The downstream request and the
// response are routed back to the captured owner only.
module obi_rr_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned OBI_ADDRW = 32,
    parameter int unsigned OBI_DATAW = 32,
    parameter int unsigned OBI_STRBW = OBI_DATAW / 8
) (
    input  logic                                 clk_i,
    input  logic                                 arst_ni,
    input  logic [NUM_REQ-1:0]                   req_i,
    input  logic [NUM_REQ-1:0][OBI_ADDRW-1:0]    addr_i,
    input  logic [NUM_REQ-1:0]                   we_i,
    input  logic [NUM_REQ-1:0][OBI_DATAW-1:0]    wdata_i,
    input  logic [NUM_REQ-1:0][OBI_STRBW-1:0]    be_i,
    output logic [NUM_REQ-1:0]                   gnt_o,
    output logic [NUM_REQ-1:0]                   rvalid_o,
    output logic [NUM_REQ-1:0][OBI_DATAW-1:0]    rdata_o,
    output logic                                 m_req_o,
    output logic [OBI_ADDRW-1:0]                 m_addr_o,
    output logic                                 m_we_o,
    output logic [OBI_DATAW-1:0]                 m_wdata_o,
    output logic [OBI_STRBW-1:0]                 m_be_o,
    input  logic                                 m_gnt_i,
    input  logic                                 m_rvalid_i,
    input  logic [OBI_DATAW-1:0]                 m_rdata_i
);

    localparam int unsigned IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [IDXW-1:0] idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Index reached by stepping 'off' places up from 'base', wrapping at
    // NUM_REQ. base < NUM_REQ and off < NUM_REQ, so one subtraction suffices.
    function automatic idx_t rr_index(input idx_t base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum + 32'd0;
        end
        return idx_t'(sum);
    endfunction

    // Successor of an index with wrap-around; the pointer moves past the winner.
    function automatic idx_t next_idx(input idx_t cur);
        idx_t nxt;
        if (32'(cur) == (NUM_REQ - 32'd1)) begin
            nxt = '0;
        end else begin
            nxt = cur + idx_t'(1);
        end
        return nxt;
    endfunction

    state_e                                state_q, state_d;
    idx_t                                  owner_q, owner_d;
    idx_t                                  ptr_q,   ptr_d;
    logic [OBI_ADDRW-1:0]                  addr_q,  addr_d;
    logic                                  we_q,    we_d;
    logic [OBI_DATAW-1:0]                  wdata_q, wdata_d;
    logic [OBI_STRBW-1:0]                  be_q,    be_d;

    logic                                  win_found_s;
    idx_t                                  win_idx_s;
    logic [NUM_REQ-1:0]                    gnt_s;
    logic [NUM_REQ-1:0]                    rvalid_s;
    logic [NUM_REQ-1:0][OBI_DATAW-1:0]     rdata_s;
    logic                                  m_req_s;

    // Round-robin search: first active requester at or above the pointer.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!win_found_s && req_i[rr_index(ptr_q, i)]) begin
                win_found_s = 1'b1;
                win_idx_s   = rr_index(ptr_q, i);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Transaction FSM: next state, capture of the winner, and response routing.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        gnt_s    = '0;
        rvalid_s = '0;
        rdata_s  = '0;
        m_req_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A stray m_rvalid_i here has no owner and is dropped.
                if (win_found_s) begin
                    gnt_s[win_idx_s] = 1'b1;
                    owner_d          = win_idx_s;
                    ptr_d            = next_idx(win_idx_s);
                    addr_d           = addr_i[win_idx_s];
                    we_d             = we_i[win_idx_s];
                    wdata_d          = wdata_i[win_idx_s];
                    be_d             = be_i[win_idx_s];
                    state_d          = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ADDR: begin
                m_req_s = 1'b1;
                if (m_gnt_i) begin
                    if (m_rvalid_i) begin
                        rvalid_s[owner_q] = 1'b1;
                        rdata_s[owner_q]  = m_rdata_i;
                        state_d           = ST_IDLE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else begin
                    state_d = ST_ADDR;
                end
            end

            ST_RESP: begin
                if (m_rvalid_i) begin
                    rvalid_s[owner_q] = 1'b1;
                    rdata_s[owner_q]  = m_rdata_i;
                    state_d           = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, owner, pointer and captured request fields.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // Grant is the same-cycle address-phase acceptance; it is forced low while
    // reset is held so every output reads zero during reset.
    assign gnt_o     = gnt_s & {NUM_REQ{arst_ni}};
    assign rvalid_o  = rvalid_s;
    assign rdata_o   = rdata_s;
    assign m_req_o   = m_req_s;
    assign m_addr_o  = addr_q;
    assign m_we_o    = we_q;
    assign m_wdata_o = wdata_q;
    assign m_be_o    = be_q;

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Bench for obi_rr_arbiter (NUM_REQ=4): directed scenarios plus randomized
// transactions, checked against a transaction-level round-robin model.
module tb_obi_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic                  clk;
    logic                  arst_n;
    logic [N-1:0]          req_v;
    logic [N-1:0][AW-1:0]  addr_v;
    logic [N-1:0]          we_v;
    logic [N-1:0][DW-1:0]  wdata_v;
    logic [N-1:0][SW-1:0]  be_v;
    logic [N-1:0]          gnt_o;
    logic [N-1:0]          rvalid_o;
    logic [N-1:0][DW-1:0]  rdata_o;
    logic                  m_req_o;
    logic [AW-1:0]         m_addr_o;
    logic                  m_we_o;
    logic [DW-1:0]         m_wdata_o;
    logic [SW-1:0]         m_be_o;
    logic                  m_gnt;
    logic                  m_rvalid;
    logic [DW-1:0]         m_rdata;

    int n_cmp;
    int n_err;
    int exp_ptr;   // model: index where the next search starts

    obi_rr_arbiter #(
        .NUM_REQ  (N),
        .OBI_ADDRW(AW),
        .OBI_DATAW(DW),
        .OBI_STRBW(SW)
    ) dut (
        .clk_i     (clk),
        .arst_ni   (arst_n),
        .req_i     (req_v),
        .addr_i    (addr_v),
        .we_i      (we_v),
        .wdata_i   (wdata_v),
        .be_i      (be_v),
        .gnt_o     (gnt_o),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .m_req_o   (m_req_o),
        .m_addr_o  (m_addr_o),
        .m_we_o    (m_we_o),
        .m_wdata_o (m_wdata_o),
        .m_be_o    (m_be_o),
        .m_gnt_i   (m_gnt),
        .m_rvalid_i(m_rvalid),
        .m_rdata_i (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Reference: first requester at or after exp_ptr, wrapping modulo N.
    function automatic int pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (exp_ptr + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic rand_upstream();
        for (int k = 0; k < N; k++) begin
            addr_v[k]  = $urandom;
            we_v[k]    = 1'($urandom);
            wdata_v[k] = $urandom;
            be_v[k]    = 4'($urandom);
        end
    endtask

    // One complete transaction starting in an IDLE cycle. Upstream fields
    // must be set by the caller; req rq must be nonzero.
    task automatic txn(input logic [N-1:0] rq, input int gdly, input bit split,
                       input int rdly, input logic [DW-1:0] rd);
        int            w;
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        logic          ew;
        logic [DW-1:0] ed;
        logic [SW-1:0] eb;
        logic          done;

        req_v    = rq;
        m_gnt    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = $urandom;
        #1;
        w = pick(rq);
        eg = '0;
        eg[w] = 1'b1;
        chk("gnt_idle", 64'(gnt_o), 64'(eg));
        chk("mreq_idle", 64'(m_req_o), 64'd0);
        chk("rvalid_idle", 64'(rvalid_o), 64'd0);
        ea = addr_v[w];
        ew = we_v[w];
        ed = wdata_v[w];
        eb = be_v[w];
        exp_ptr = (w + 1) % N;
        nxt();

        // Address phase: captured fields held until downstream grant.
        for (int g = 0; g <= gdly; g++) begin
            req_v = 4'($urandom);
            rand_upstream();
            done     = (g == gdly) && !split;
            m_gnt    = (g == gdly);
            m_rvalid = done;
            m_rdata  = done ? rd : 32'($urandom);
            #1;
            chk("mreq_addr", 64'(m_req_o), 64'd1);
            chk("maddr", 64'(m_addr_o), 64'(ea));
            chk("mwe", 64'(m_we_o), 64'(ew));
            chk("mwdata", 64'(m_wdata_o), 64'(ed));
            chk("mbe", 64'(m_be_o), 64'(eb));
            chk("gnt_busy", 64'(gnt_o), 64'd0);
            if (done) begin
                chk("rvalid_fast", 64'(rvalid_o), 64'(eg));
                for (int k = 0; k < N; k++)
                    chk("rdata_fast", 64'(rdata_o[k]), (k == w) ? 64'(rd) : 64'd0);
            end else begin
                chk("rvalid_wait", 64'(rvalid_o), 64'd0);
            end
            nxt();
        end

        // Response phase for split transactions.
        if (split) begin
            for (int r = 0; r <= rdly; r++) begin
                req_v = 4'($urandom);
                rand_upstream();
                m_gnt    = 1'b0;
                m_rvalid = (r == rdly);
                m_rdata  = (r == rdly) ? rd : 32'($urandom);
                #1;
                chk("mreq_resp", 64'(m_req_o), 64'd0);
                chk("gnt_resp", 64'(gnt_o), 64'd0);
                if (r == rdly) begin
                    chk("rvalid_split", 64'(rvalid_o), 64'(eg));
                    for (int k = 0; k < N; k++)
                        chk("rdata_split", 64'(rdata_o[k]), (k == w) ? 64'(rd) : 64'd0);
                end else begin
                    chk("rvalid_resp_wait", 64'(rvalid_o), 64'd0);
                end
                nxt();
            end
        end
        m_gnt    = 1'b0;
        m_rvalid = 1'b0;
    endtask

    // An IDLE cycle with no requests; stray downstream handshakes are ignored.
    task automatic idle_cycle();
        req_v    = '0;
        m_gnt    = 1'($urandom);
        m_rvalid = 1'($urandom);
        m_rdata  = $urandom;
        #1;
        chk("gnt_none", 64'(gnt_o), 64'd0);
        chk("rvalid_stray", 64'(rvalid_o), 64'd0);
        chk("mreq_none", 64'(m_req_o), 64'd0);
        nxt();
        m_gnt    = 1'b0;
        m_rvalid = 1'b0;
    endtask

    initial begin
        logic [N-1:0] rq;
        n_cmp    = 0;
        n_err    = 0;
        exp_ptr  = 0;
        arst_n   = 1'b0;
        req_v    = '1;
        m_gnt    = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 32'hFFFF_FFFF;
        rand_upstream();

        // Reset state: all outputs zero even with requests present.
        repeat (2) @(posedge clk);
        #2;
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("rst_mreq", 64'(m_req_o), 64'd0);
        chk("rst_maddr", 64'(m_addr_o), 64'd0);
        chk("rst_rdata", 64'(rdata_o[0]), 64'd0);
        req_v    = '0;
        m_rvalid = 1'b0;
        arst_n   = 1'b1;
        nxt();

        // Contention between 0 and 1: grants alternate 0,1,0,1.
        for (int t = 0; t < 4; t++) begin
            rand_upstream();
            txn(4'b0011, t % 2, 1'b0, 0, $urandom);
        end

        // Single read: gnt at cycle 0, downstream gnt+rvalid at cycle 3.
        rand_upstream();
        addr_v[0] = 32'h0000_1000;
        we_v[0]   = 1'b0;
        txn(4'b0001, 2, 1'b0, 0, 32'hDEAD_BEEF);
        idle_cycle();

        // Split phases: grant in first ADDR cycle, rvalid 5 cycles later.
        rand_upstream();
        txn(4'b1000, 0, 1'b1, 4, $urandom);

        // Write capture by requester 1; inputs scrambled after the grant.
        rand_upstream();
        addr_v[1]  = 32'h0000_2004;
        we_v[1]    = 1'b1;
        wdata_v[1] = 32'hA5A5_A5A5;
        be_v[1]    = 4'hC;
        txn(4'b0010, 3, 1'b0, 0, $urandom);

        // Wrap: pointer to 3 via a lone request at 2, then 0101 gives 0 then 2.
        rand_upstream();
        txn(4'b0100, 0, 1'b0, 0, $urandom);
        rand_upstream();
        txn(4'b0101, 1, 1'b0, 0, $urandom);
        rand_upstream();
        txn(4'b0101, 0, 1'b1, 1, $urandom);

        // Reset while in RESP.
        rand_upstream();
        req_v    = 4'b0010;
        #1;
        nxt();
        m_gnt    = 1'b1;
        m_rvalid = 1'b0;
        nxt();
        m_gnt    = 1'b0;
        req_v    = 4'b1111;
        #1;
        chk("resp_mreq", 64'(m_req_o), 64'd0);
        arst_n = 1'b0;
        #1;
        chk("midrst_gnt", 64'(gnt_o), 64'd0);
        chk("midrst_mreq", 64'(m_req_o), 64'd0);
        chk("midrst_rvalid", 64'(rvalid_o), 64'd0);
        chk("midrst_maddr", 64'(m_addr_o), 64'd0);
        chk("midrst_mwe", 64'(m_we_o), 64'd0);
        chk("midrst_mwdata", 64'(m_wdata_o), 64'd0);
        chk("midrst_mbe", 64'(m_be_o), 64'd0);
        exp_ptr = 0;
        nxt();
        arst_n   = 1'b1;
        req_v    = '0;
        m_rvalid = 1'b1;
        m_rdata  = 32'h1234_5678;
        #1;
        chk("late_rvalid", 64'(rvalid_o), 64'd0);
        chk("late_rdata", 64'(rdata_o[1]), 64'd0);
        nxt();
        m_rvalid = 1'b0;
        rand_upstream();
        txn(4'b1111, 0, 1'b0, 0, $urandom);

        // Randomized transactions against the model.
        for (int t = 0; t < 300; t++) begin
            if (($urandom % 4) == 0) idle_cycle();
            rq = 4'($urandom);
            if (rq == 4'b0000) rq = 4'b0001 << ($urandom % N);
            rand_upstream();
            txn(rq, int'($urandom % 4), 1'($urandom), int'($urandom % 4), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
